irq_ctrl: RTL and testbench
===========================

# irq_ctrl

External interrupt controller between the peripheral bridge and CP0. Collects up to six device request lines, synchronises and latches them, applies mask and level/edge configuration, and picks one winner by fixed priority. Drives the winner one-hot onto CP0's `HWInt[5:0]` and tracks it through acknowledge (pipeline takes the interrupt) and end-of-interrupt (handler writes EOI). Configured by the CPU through a small word-addressed register port on the bridge.

## Interface
- `NSRC`, 6: number of sources. Fixed to the CP0 `HWInt` width; other values are unsupported.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: **asynchronous, active-low** (0 = reset).
- `src_irq`  in  6: raw device requests. Asynchronous to `clk`.
- `int_taken`  in  1: one-cycle pulse from the M-stage when CP0 accepts an interrupt.
- `we`  in  1: register write strobe.
- `addr`  in  2: register select (word address bits [3:2]).
- `wdata`  in  32: write data.
- `rdata`  out  32: read data. Combinational from `addr`.
- `hwint`  out  6: one-hot request to CP0 `HWInt`.
- `in_service`  out  1: high in SERVICE state.

## Operation
- Registers. Unused bits read 0 and ignore writes.
  - `addr`=0 MASK: rw, bits [5:0], 1 = enabled.
  - `addr`=1 EDGE: rw, bits [5:0], 1 = rising-edge, 0 = level.
  - `addr`=2 PEND: read returns `pend[5:0]`. Writing 1 to a bit clears that edge-pending bit. Writes have no effect on level bits.
  - `addr`=3 STAT: read returns `{28'b0, in_service, cur_id[2:0]}`. Any write is EOI.
- Input path: synchroniser gives `s`, plus a delay register `s_d <= s`.
  - Level bit: `pend[i] <= s[i]`.
  - Edge bit: `pend[i] <= pend[i] | (s[i] & ~s_d[i])`, then cleared by a PEND write-1 or by acceptance.
  - Set and clear of the same bit in the same cycle: set wins.
- Arbitration: `req = pend & MASK`. Winner is the lowest set index (0 = highest priority).
- FSM states are IDLE, PENDING, SERVICE.
  - IDLE: when `req != 0`, go to PENDING and set `cur_id` = winner.
  - PENDING: re-arbitrate every cycle, so `cur_id` follows the current winner, including a higher-priority arrival.
    - If `req == 0`, go to IDLE.
    - On `int_taken`, go to SERVICE with `cur_id` frozen, and clear `pend[cur_id]` if that source is edge-configured.
  - SERVICE: no arbitration output. An EOI write goes to IDLE.
- Events outside their state are ignored:
  - `int_taken` in IDLE or SERVICE.
  - EOI in IDLE or PENDING.
- Outputs:
  - `hwint = (state==PENDING) ? (1 << cur_id) : 0`.
  - `in_service = (state==SERVICE)`.
- No nesting: while in SERVICE, new requests only accumulate in `pend`.

## Timing
- Reset values:
  - state IDLE, `cur_id` 0, MASK 0, EDGE 0, `pend` 0, synchroniser and `s_d` 0.
  - Outputs: `hwint` 0, `in_service` 0, `rdata` = MASK read (0).
- Latency, `src_irq` rising before edge E0, source unmasked, state IDLE:
  - with the synchroniser enabled, `pend` sets after E2, state PENDING after E3, `hwint` visible after E3;
  - without it, each of those is one edge earlier.
- `int_taken` at edge E: `hwint` is 0 from after E.
- EOI write at edge E: IDLE after E. A still-pending request reaches PENDING after E+1.
- Register writes take effect at the write edge. A MASK write clearing the current winner in PENDING drops `hwint` after the next edge, or re-targets it if another request remains.
- Reset asserted mid-operation: all state clears immediately (asynchronous), and `hwint` drops without waiting for a clock.

## Configuration
- `IRQ_SYNC2_EN` defined: two-flop synchroniser (`s1 <= src_irq; s <= s1`), giving the latency above.
- Undefined: single register stage (`s <= src_irq`), for sources already synchronous to `clk`. Every latency figure is one cycle shorter; behaviour is otherwise identical.

## Test plan
- Reset / register access: after reset, reads of 0, 1, 2, 3 all return 0. Write MASK=0x3F and EDGE=0x05, read back 0x3F and 0x05; a write to bit 6 reads back 0.
- Basic flow:
  - MASK=0x3F, `src_irq[3]` level high → `hwint`=0x08 after 4 edges (with `IRQ_SYNC2_EN`).
  - `int_taken` pulse → `hwint`=0, STAT=0x0B.
  - EOI with line still high → `hwint`=0x08 again one edge later.
- Priority / re-arbitration: `src_irq[4]` high, then in PENDING raise `src_irq[1]` → `hwint` changes 0x10 → 0x02 and `cur_id`=1. Drop both before `int_taken` → IDLE, `hwint`=0.
- Edge latch:
  - EDGE=0x01, one-cycle pulse on `src_irq[0]` → PEND=0x01 and `hwint`=0x01.
  - `int_taken` → PEND=0x00.
  - A second pulse during SERVICE → PEND=0x01, `hwint` stays 0 until EOI.
- Clear collision: write PEND=0x01 on the same edge a new edge on source 0 is detected → PEND bit 0 remains 1.
- Async reset: in PENDING with `hwint`=0x04, pull `reset` low between clock edges → `hwint`=0 and `in_service`=0 immediately. MASK reads 0 after release.

Source files
------------

// File: rtl/irq_ctrl.sv
// Six-source external interrupt controller: synchronise/latch requests, mask, fixed-priority
// arbitration and an IDLE/PENDING/SERVICE handshake with CP0. Define IRQ_SYNC2_EN for a two-flop input synchroniser.
module irq_ctrl #(
   parameter int NSRC = 6
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NSRC-1:0] src_irq,
   input  logic            int_taken,
   input  logic            we,
   input  logic [1:0]      addr,
   input  logic [31:0]     wdata,
   output logic [31:0]     rdata,
   output logic [NSRC-1:0] hwint,
   output logic            in_service
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      SERVICE = 2'd2
   } state_e;

   // Lowest set index wins; index 0 is the highest priority.
   function automatic logic [2:0] pick_winner(input logic [NSRC-1:0] r);
      logic [2:0] w;
      w = 3'd0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (r[i]) begin
            w = 3'(i);
         end
      end
      return w;
   endfunction

   state_e          state_q, state_d;
   logic [2:0]      cur_id_q, cur_id_d;
   logic [NSRC-1:0] mask_q, mask_d;
   logic [NSRC-1:0] edge_q, edge_d;
   logic [NSRC-1:0] pend_q, pend_d;
   logic [NSRC-1:0] s_q, s_d_q;
   logic [NSRC-1:0] hwint_q, hwint_d;
   logic            in_service_q, in_service_d;
   logic [NSRC-1:0] req_s;
   logic [2:0]      win_s;
   logic            accept_s;
   logic            eoi_s;
   logic            pend_wr_s;
   logic            unused_wdata_s;

   assign unused_wdata_s = ^wdata[31:NSRC];

`ifdef IRQ_SYNC2_EN
   logic [NSRC-1:0] s1_q;

   // Two-flop synchroniser for requests asynchronous to clk.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_q <= '0;
         s_q  <= '0;
      end else begin
         s1_q <= src_irq;
         s_q  <= s1_q;
      end
   end
`else
   // Single capture stage for requests already synchronous to clk.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s_q <= '0;
      end else begin
         s_q <= src_irq;
      end
   end
`endif

   // Arbitration, handshake FSM next state and registered output values.
   always_comb begin
      req_s        = pend_q & mask_q;
      win_s        = pick_winner(req_s);
      eoi_s        = we && (addr == 2'd3);
      state_d      = state_q;
      cur_id_d     = cur_id_q;
      accept_s     = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_s != '0) begin
               state_d  = PENDING;
               cur_id_d = win_s;
            end else begin
               state_d  = IDLE;
            end
         end
         PENDING: begin
            if (req_s == '0) begin
               state_d  = IDLE;
            end else if (int_taken) begin
               state_d  = SERVICE;
               accept_s = 1'b1;
            end else begin
               cur_id_d = win_s;
            end
         end
         SERVICE: begin
            if (eoi_s) begin
               state_d = IDLE;
            end else begin
               state_d = SERVICE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      hwint_d      = (state_d == PENDING) ? (NSRC'(1) << cur_id_d) : '0;
      in_service_d = (state_d == SERVICE);
   end

   // Pending latch: level bits follow the input, edge bits hold until cleared; a new edge beats a clear.
   always_comb begin
      pend_wr_s = we && (addr == 2'd2);
      mask_d    = (we && (addr == 2'd0)) ? wdata[NSRC-1:0] : mask_q;
      edge_d    = (we && (addr == 2'd1)) ? wdata[NSRC-1:0] : edge_q;
      pend_d    = pend_q;
      for (int i = 0; i < NSRC; i++) begin
         if (edge_q[i]) begin
            pend_d[i] = (s_q[i] & ~s_d_q[i]) |
                        (pend_q[i] & ~((pend_wr_s & wdata[i]) | (accept_s & (cur_id_q == 3'(i)))));
         end else begin
            pend_d[i] = s_q[i];
         end
      end
   end

   // Controller state, configuration and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         cur_id_q     <= 3'd0;
         mask_q       <= '0;
         edge_q       <= '0;
         pend_q       <= '0;
         s_d_q        <= '0;
         hwint_q      <= '0;
         in_service_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cur_id_q     <= cur_id_d;
         mask_q       <= mask_d;
         edge_q       <= edge_d;
         pend_q       <= pend_d;
         s_d_q        <= s_q;
         hwint_q      <= hwint_d;
         in_service_q <= in_service_d;
      end
   end

   // Register read mux.
   always_comb begin
      case (addr)
         2'd0:    rdata = {{(32-NSRC){1'b0}}, mask_q};
         2'd1:    rdata = {{(32-NSRC){1'b0}}, edge_q};
         2'd2:    rdata = {{(32-NSRC){1'b0}}, pend_q};
         2'd3:    rdata = {28'd0, in_service_q, cur_id_q};
         default: rdata = 32'd0;
      endcase
   end

   assign hwint      = hwint_q;
   assign in_service = in_service_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: expectations are queued when stimulus is applied and
// compared against DUT outputs sampled on the falling clock edge.
module tb_irq_ctrl;

`ifdef IRQ_SYNC2_EN
   localparam int SL = 2;
`else
   localparam int SL = 1;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [5:0]  src_irq = 6'd0;
   logic        int_taken = 1'b0;
   logic        we = 1'b0;
   logic [1:0]  addr = 2'd0;
   logic [31:0] wdata = 32'd0;
   logic [31:0] rdata;
   logic [5:0]  hwint;
   logic        in_service;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;
   exp_t sb[$];

   irq_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .src_irq    (src_irq),
      .int_taken  (int_taken),
      .we         (we),
      .addr       (addr),
      .wdata      (wdata),
      .rdata      (rdata),
      .hwint      (hwint),
      .in_service (in_service)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input logic [31:0] exp);
      exp_t e;
      e.tag = tag;
      e.exp = exp;
      sb.push_back(e);
   endtask

   task automatic pop_cmp(input logic [31:0] obs);
      exp_t e;
      if (sb.size() == 0) begin
         check_eq("sb_underflow", obs, ~obs);
      end else begin
         e = sb.pop_front();
         check_eq(e.tag, obs, e.exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      we = 1'b1;
      addr = a;
      wdata = d;
      @(negedge clk);
      we = 1'b0;
      wdata = 32'd0;
      addr = 2'd0;
   endtask

   task automatic rd_cmp(input logic [1:0] a, input string tag, input logic [31:0] exp);
      push(tag, exp);
      addr = a;
      #1;
      pop_cmp(rdata);
      addr = 2'd0;
   endtask

   task automatic out_cmp(input string tag, input logic [5:0] exp_hw, input logic exp_svc);
      push({tag, "_hwint"}, {26'd0, exp_hw});
      push({tag, "_insvc"}, {31'd0, exp_svc});
      pop_cmp({26'd0, hwint});
      pop_cmp({31'd0, in_service});
   endtask

   task automatic pulse_taken();
      int_taken = 1'b1;
      @(negedge clk);
      int_taken = 1'b0;
   endtask

   initial begin
      // Reset state
      cycles(2);
      out_cmp("in_reset", 6'h00, 1'b0);
      reset = 1'b1;
      cycles(1);
      for (int a = 0; a < 4; a++) begin
         rd_cmp(2'(a), $sformatf("rst_rd%0d", a), 32'd0);
      end
      pulse_taken();
      out_cmp("taken_in_idle", 6'h00, 1'b0);

      // Register access
      wr(2'd0, 32'h3F);
      wr(2'd1, 32'h05);
      rd_cmp(2'd0, "mask_rb", 32'h3F);
      rd_cmp(2'd1, "edge_rb", 32'h05);
      wr(2'd0, 32'h7F);
      rd_cmp(2'd0, "mask_bit6", 32'h3F);
      wr(2'd1, 32'h00);

      // Basic level flow on source 3
      src_irq[3] = 1'b1;
      cycles(SL + 1);
      out_cmp("lvl_early", 6'h00, 1'b0);
      cycles(1);
      out_cmp("lvl_hw", 6'h08, 1'b0);
      pulse_taken();
      out_cmp("lvl_taken", 6'h00, 1'b1);
      rd_cmp(2'd3, "lvl_stat", 32'h0B);
      wr(2'd3, 32'd0);
      out_cmp("lvl_eoi", 6'h00, 1'b0);
      cycles(1);
      out_cmp("lvl_reassert", 6'h08, 1'b0);
      pulse_taken();
      src_irq[3] = 1'b0;
      cycles(4);
      out_cmp("lvl_svc_hold", 6'h00, 1'b1);
      wr(2'd3, 32'd0);
      cycles(2);
      out_cmp("lvl_done", 6'h00, 1'b0);

      // Priority and re-arbitration
      src_irq[4] = 1'b1;
      cycles(SL + 2);
      out_cmp("pri_src4", 6'h10, 1'b0);
      rd_cmp(2'd3, "pri_stat4", 32'h04);
      src_irq[1] = 1'b1;
      cycles(SL + 2);
      out_cmp("pri_src1", 6'h02, 1'b0);
      rd_cmp(2'd3, "pri_stat1", 32'h01);
      src_irq[1] = 1'b0;
      src_irq[4] = 1'b0;
      cycles(SL + 2);
      out_cmp("pri_drop", 6'h00, 1'b0);

      // Edge latch on source 0
      wr(2'd1, 32'h01);
      src_irq[0] = 1'b1;
      cycles(1);
      src_irq[0] = 1'b0;
      cycles(SL + 1);
      out_cmp("edge_hw", 6'h01, 1'b0);
      rd_cmp(2'd2, "edge_pend", 32'h01);
      pulse_taken();
      rd_cmp(2'd2, "edge_accept_clr", 32'h00);
      out_cmp("edge_taken", 6'h00, 1'b1);
      src_irq[0] = 1'b1;
      cycles(1);
      src_irq[0] = 1'b0;
      cycles(SL + 2);
      rd_cmp(2'd2, "edge_svc_pend", 32'h01);
      out_cmp("edge_svc_hold", 6'h00, 1'b1);
      wr(2'd3, 32'd0);
      out_cmp("edge_eoi", 6'h00, 1'b0);
      cycles(1);
      out_cmp("edge_repend", 6'h01, 1'b0);
      pulse_taken();
      rd_cmp(2'd2, "edge_accept2", 32'h00);
      wr(2'd3, 32'd0);
      cycles(2);
      out_cmp("edge_idle", 6'h00, 1'b0);

      // Clear collides with a newly detected edge: set wins
      src_irq[0] = 1'b1;
      cycles(SL);
      wr(2'd2, 32'h01);
      rd_cmp(2'd2, "collide_pend", 32'h01);
      wr(2'd2, 32'h01);
      rd_cmp(2'd2, "w1c_pend", 32'h00);
      cycles(1);
      out_cmp("w1c_idle", 6'h00, 1'b0);
      src_irq[0] = 1'b0;
      wr(2'd1, 32'h00);

      // Asynchronous reset while PENDING
      src_irq[2] = 1'b1;
      cycles(SL + 2);
      out_cmp("ar_pending", 6'h04, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      out_cmp("ar_async", 6'h00, 1'b0);
      src_irq[2] = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      cycles(1);
      rd_cmp(2'd0, "ar_mask", 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
